// File: rtl/nios2e_jtag_debug_cmd_sysclk.sv
// System-clock side of the JTAG debug command path: synchronises update strobes,
// captures the TCK-domain command, holds it until accepted, then fires one pulse.
module nios2e_jtag_debug_cmd_sysclk #(
  parameter int DR_W        = 38,
  parameter int IR_W        = 2,
  parameter int SYNC_STAGES = 2,
  parameter int ACT_BIT     = 35
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [IR_W-1:0]      ir_in,
  input  logic [DR_W-1:0]      sr,
  input  logic                 vs_uir,
  input  logic                 vs_udr,
  input  logic                 cmd_ack,
  input  logic                 clr_overrun,
  output logic [DR_W-1:0]      jdo,
  output logic [IR_W-1:0]      ir_q,
  output logic [IR_W-1:0]      cmd_ir,
  output logic                 cmd_valid,
  output logic [2**IR_W-1:0]   take_action,
  output logic [2**IR_W-1:0]   take_no_action,
  output logic                 overrun
);
  localparam int NACT = 2**IR_W;

  typedef enum logic [1:0] {IDLE, PEND, FIRE} state_t;

  state_t                 r_state, w_state_nxt;
  logic [SYNC_STAGES-1:0] r_uir_sync, r_udr_sync;
  logic                   r_uir_dly, r_udr_dly;
  logic [DR_W-1:0]        r_jdo;
  logic [IR_W-1:0]        r_ir_q, r_cmd_ir;
  logic                   r_cmd_valid, r_overrun;
  logic [NACT-1:0]        r_take_action, r_take_no_action;
  logic                   w_uir_ev, w_udr_ev, w_capture, w_fire, w_overrun_set;
  logic [NACT-1:0]        w_onehot;

  // Edge registers reset low, so a strobe already high at reset release gives one event.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_uir_sync <= '0;
      r_udr_sync <= '0;
      r_uir_dly  <= 1'b0;
      r_udr_dly  <= 1'b0;
    end else begin
      r_uir_sync <= {r_uir_sync[SYNC_STAGES-2:0], vs_uir};
      r_udr_sync <= {r_udr_sync[SYNC_STAGES-2:0], vs_udr};
      r_uir_dly  <= r_uir_sync[SYNC_STAGES-1];
      r_udr_dly  <= r_udr_sync[SYNC_STAGES-1];
    end
  end

  assign w_uir_ev = r_uir_sync[SYNC_STAGES-1] & ~r_uir_dly;
  assign w_udr_ev = r_udr_sync[SYNC_STAGES-1] & ~r_udr_dly;
  assign w_onehot = {{(NACT-1){1'b0}}, 1'b1} << r_cmd_ir;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_capture     = 1'b0;
    w_fire        = 1'b0;
    w_overrun_set = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_udr_ev) begin
          w_capture   = 1'b1;
          w_state_nxt = PEND;
        end
      end
      PEND: begin
        w_overrun_set = w_udr_ev;
        if (cmd_ack) begin
          w_fire      = 1'b1;
          w_state_nxt = FIRE;
        end
      end
      FIRE: begin
        w_overrun_set = w_udr_ev;
        w_state_nxt   = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_jdo            <= '0;
      r_ir_q           <= '0;
      r_cmd_ir         <= '0;
      r_cmd_valid      <= 1'b0;
      r_take_action    <= '0;
      r_take_no_action <= '0;
      r_overrun        <= 1'b0;
    end else begin
      if (w_uir_ev) r_ir_q <= ir_in;
      // ir_in taken directly so a UIR landing on the same edge is honoured.
      if (w_capture) begin
        r_jdo    <= sr;
        r_cmd_ir <= ir_in;
      end
      r_cmd_valid      <= (w_state_nxt == PEND);
      r_take_action    <= (w_fire &&  r_jdo[ACT_BIT]) ? w_onehot : '0;
      r_take_no_action <= (w_fire && !r_jdo[ACT_BIT]) ? w_onehot : '0;
      if (w_overrun_set)    r_overrun <= 1'b1;
      else if (clr_overrun) r_overrun <= 1'b0;
    end
  end

  assign jdo            = r_jdo;
  assign ir_q           = r_ir_q;
  assign cmd_ir         = r_cmd_ir;
  assign cmd_valid      = r_cmd_valid;
  assign take_action    = r_take_action;
  assign take_no_action = r_take_no_action;
  assign overrun        = r_overrun;
endmodule

// File: tb/tb_nios2e_jtag_debug_cmd_sysclk.sv
// Randomised and directed bench for the debug command receiver, with a
// cycle-level reference model plus a wide-parameter instance.
module tb_nios2e_jtag_debug_cmd_sysclk;
  localparam int S = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  ir_in = '0;
  logic [37:0] sr = '0;
  logic        vs_uir = 1'b0, vs_udr = 1'b0, cmd_ack = 1'b0, clr_overrun = 1'b0;
  logic [37:0] jdo;
  logic [1:0]  ir_q, cmd_ir;
  logic        cmd_valid, overrun;
  logic [3:0]  take_action, take_no_action;

  logic [2:0]  w_ir = '0;
  logic [63:0] w_sr = '0;
  logic        w_uir = 1'b0, w_udr = 1'b0, w_ack = 1'b0, w_clr = 1'b0;
  logic [63:0] w_jdo;
  logic [2:0]  w_ir_q, w_cmd_ir;
  logic        w_valid, w_ovr;
  logic [7:0]  w_ta, w_tna;

  int n_checks = 0, n_errors = 0;

  always #5 clk = ~clk;

  nios2e_jtag_debug_cmd_sysclk #(.DR_W(38), .IR_W(2), .SYNC_STAGES(2), .ACT_BIT(35)) u_dut (
    .clk(clk), .reset_n(reset_n), .ir_in(ir_in), .sr(sr), .vs_uir(vs_uir), .vs_udr(vs_udr),
    .cmd_ack(cmd_ack), .clr_overrun(clr_overrun), .jdo(jdo), .ir_q(ir_q), .cmd_ir(cmd_ir),
    .cmd_valid(cmd_valid), .take_action(take_action), .take_no_action(take_no_action),
    .overrun(overrun));

  nios2e_jtag_debug_cmd_sysclk #(.DR_W(64), .IR_W(3), .SYNC_STAGES(3), .ACT_BIT(60)) u_dut_w (
    .clk(clk), .reset_n(reset_n), .ir_in(w_ir), .sr(w_sr), .vs_uir(w_uir), .vs_udr(w_udr),
    .cmd_ack(w_ack), .clr_overrun(w_clr), .jdo(w_jdo), .ir_q(w_ir_q), .cmd_ir(w_cmd_ir),
    .cmd_valid(w_valid), .take_action(w_ta), .take_no_action(w_tna), .overrun(w_ovr));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: strobe sample history plus abstract command state.
  logic [S+1:0] uir_h, udr_h;
  logic [37:0]  m_jdo;
  logic [1:0]   m_ir_q, m_cmd_ir;
  logic         m_pend, m_fire, m_ovr;
  logic [3:0]   m_ta, m_tna;
  int           ta_cnt, tna_cnt;
  logic [3:0]   ta_last, tna_last;

  task automatic model_reset();
    uir_h = '0; udr_h = '0; m_jdo = '0; m_ir_q = '0; m_cmd_ir = '0;
    m_pend = 0; m_fire = 0; m_ovr = 0; m_ta = '0; m_tna = '0;
  endtask

  task automatic model_edge();
    logic ev_u, ev_d, busy, pend0, fire0;
    if (!reset_n) begin
      model_reset();
      return;
    end
    uir_h = {uir_h[S:0], vs_uir};
    udr_h = {udr_h[S:0], vs_udr};
    ev_u = uir_h[S] & ~uir_h[S+1];
    ev_d = udr_h[S] & ~udr_h[S+1];
    pend0 = m_pend; fire0 = m_fire; busy = pend0 | fire0;
    if (ev_u) m_ir_q = ir_in;
    m_ta = '0; m_tna = '0;
    if (fire0) m_fire = 0;
    if (pend0 && cmd_ack) begin
      m_pend = 0; m_fire = 1;
      if (m_jdo[35]) m_ta = 4'd1 << m_cmd_ir;
      else           m_tna = 4'd1 << m_cmd_ir;
    end
    if (!busy && ev_d) begin
      m_jdo = sr; m_cmd_ir = ir_in; m_pend = 1;
    end
    if (busy && ev_d)     m_ovr = 1;
    else if (clr_overrun) m_ovr = 0;
  endtask

  task automatic compare_all();
    chk("jdo", 64'(jdo), 64'(m_jdo));
    chk("ir_q", 64'(ir_q), 64'(m_ir_q));
    chk("cmd_ir", 64'(cmd_ir), 64'(m_cmd_ir));
    chk("cmd_valid", 64'(cmd_valid), 64'(m_pend));
    chk("take_action", 64'(take_action), 64'(m_ta));
    chk("take_no_action", 64'(take_no_action), 64'(m_tna));
    chk("overrun", 64'(overrun), 64'(m_ovr));
    if (take_action != 0)    begin ta_cnt++;  ta_last = take_action;    end
    if (take_no_action != 0) begin tna_cnt++; tna_last = take_no_action; end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic strobe(input logic u, input logic d, input int hold);
    vs_uir = u; vs_udr = d;
    repeat (hold) tick();
    vs_uir = 0; vs_udr = 0;
    repeat (S + 1) tick();
  endtask

  task automatic clr_pulses();
    ta_cnt = 0; tna_cnt = 0; ta_last = '0; tna_last = '0;
  endtask

  task automatic wait_valid(input string tag, output int n);
    n = 0;
    while (!cmd_valid && n < 20) begin tick(); n++; end
    if (!cmd_valid) chk({tag, "_timeout"}, 64'(cmd_valid), 64'd1);
  endtask

  initial begin
    int n;
    logic [37:0] a, b;
    model_reset();
    clr_pulses();

    // Reset with random inputs.
    repeat (5) begin
      ir_in = 2'($urandom); sr = {6'($urandom), 32'($urandom)};
      vs_uir = 1'($urandom); vs_udr = 1'($urandom);
      cmd_ack = 1'($urandom); clr_overrun = 1'($urandom);
      tick();
    end
    chk("rst_valid", 64'(cmd_valid), 0);
    chk("rst_jdo", 64'(jdo), 0);
    chk("rst_ovr", 64'(overrun), 0);
    vs_uir = 0; vs_udr = 0; cmd_ack = 0; clr_overrun = 0;
    reset_n = 1;
    repeat (10) tick();
    chk("post_rst_valid", 64'(cmd_valid), 0);
    chk("post_rst_jdo", 64'(jdo), 0);

    // Basic command.
    clr_pulses();
    ir_in = 2;
    strobe(1, 0, S + 1);
    chk("basic_ir_q", 64'(ir_q), 2);
    sr = 38'h08_0000_1234;
    vs_udr = 1;
    wait_valid("basic", n);
    chk("basic_lat", 64'(n), 3);
    chk("basic_jdo", 64'(jdo), 64'h08_0000_1234);
    chk("basic_cmd_ir", 64'(cmd_ir), 2);
    vs_udr = 0;
    repeat (4) tick();
    cmd_ack = 1; tick(); cmd_ack = 0;
    chk("basic_ta", 64'(take_action), 4'b0100);
    chk("basic_valid_drop", 64'(cmd_valid), 0);
    repeat (S + 1) tick();
    chk("basic_ta_cnt", 64'(ta_cnt), 1);
    chk("basic_tna_cnt", 64'(tna_cnt), 0);

    // No-action path with ack tied high.
    clr_pulses();
    cmd_ack = 1; ir_in = 0;
    sr = {6'($urandom), 32'($urandom)}; sr[35] = 0;
    strobe(0, 1, S + 1);
    repeat (3) tick();
    cmd_ack = 0;
    chk("noact_cnt", 64'(tna_cnt), 1);
    chk("noact_tna", 64'(tna_last), 4'b0001);
    chk("noact_ta_cnt", 64'(ta_cnt), 0);

    // Overrun: second update-DR while pending.
    clr_pulses();
    a = {6'($urandom), 32'($urandom)};
    b = ~a;
    ir_in = 1; sr = a;
    strobe(0, 1, S + 1);
    sr = b;
    strobe(0, 1, S + 1);
    chk("ovr_set", 64'(overrun), 1);
    chk("ovr_jdo_hold", 64'(jdo), 64'(a));
    cmd_ack = 1; tick(); cmd_ack = 0;
    repeat (S + 3) tick();
    chk("ovr_pulse_cnt", 64'(ta_cnt + tna_cnt), 1);
    clr_overrun = 1; tick(); clr_overrun = 0;
    chk("ovr_clr", 64'(overrun), 0);
    sr = a; strobe(0, 1, S + 1);
    vs_udr = 1; tick(); tick(); clr_overrun = 1; tick(); clr_overrun = 0;
    chk("ovr_set_wins", 64'(overrun), 1);
    vs_udr = 0; repeat (S + 1) tick();
    clr_overrun = 1; tick(); clr_overrun = 0;
    chk("ovr_clr2", 64'(overrun), 0);
    cmd_ack = 1; tick(); cmd_ack = 0; repeat (S + 2) tick();

    // Simultaneous UIR and UDR.
    ir_in = 3; sr = {6'($urandom), 32'($urandom)};
    vs_uir = 1; vs_udr = 1;
    wait_valid("simul", n);
    chk("simul_cmd_ir", 64'(cmd_ir), 3);
    chk("simul_ir_q", 64'(ir_q), 3);
    vs_uir = 0; vs_udr = 0; repeat (S + 1) tick();
    cmd_ack = 1; tick(); cmd_ack = 0; repeat (S + 2) tick();

    // Reset while pending.
    clr_pulses();
    sr = {6'($urandom), 32'($urandom)};
    strobe(0, 1, S + 1);
    chk("mid_pend", 64'(cmd_valid), 1);
    reset_n = 0; model_reset(); #1; compare_all();
    chk("mid_rst_valid", 64'(cmd_valid), 0);
    chk("mid_rst_ovr", 64'(overrun), 0);
    cmd_ack = 1; repeat (2) tick(); cmd_ack = 0;
    reset_n = 1; repeat (3) tick();
    chk("mid_rst_no_pulse", 64'(ta_cnt + tna_cnt), 0);
    strobe(0, 1, S + 1);
    cmd_ack = 1; tick(); cmd_ack = 0; repeat (S + 2) tick();
    chk("mid_rst_next", 64'(ta_cnt + tna_cnt), 1);

    // Randomised traffic against the model.
    for (int i = 0; i < 60; i++) begin
      int hold;
      ir_in = 2'($urandom); sr = {6'($urandom), 32'($urandom)};
      hold = $urandom_range(S + 1, S + 4);
      vs_uir = 1'($urandom); vs_udr = 1'($urandom);
      repeat (hold) begin
        cmd_ack = 1'($urandom); clr_overrun = ($urandom_range(0, 5) == 0);
        tick();
      end
      vs_uir = 0; vs_udr = 0;
      repeat ($urandom_range(S + 1, S + 5)) begin
        cmd_ack = 1'($urandom); clr_overrun = ($urandom_range(0, 5) == 0);
        tick();
      end
    end
    cmd_ack = 0; clr_overrun = 0;
    repeat (5) tick();

    // Wide-parameter instance: 4-edge latency, pulse on bit cmd_ir of 8.
    for (int i = 0; i < 6; i++) begin
      logic [2:0]  ir;
      logic [63:0] d;
      ir = 3'($urandom);
      d = {32'($urandom), 32'($urandom)};
      w_ir = ir; w_sr = d; w_uir = 1; w_udr = 1;
      n = 0;
      while (!w_valid && n < 20) begin tick(); n++; end
      chk("w_lat", 64'(n), 4);
      chk("w_jdo", w_jdo, d);
      chk("w_cmd_ir", 64'(w_cmd_ir), 64'(ir));
      chk("w_ir_q", 64'(w_ir_q), 64'(ir));
      w_uir = 0; w_udr = 0;
      w_ack = 1; tick(); w_ack = 0;
      chk("w_ta", 64'(w_ta), d[60] ? 64'(8'd1 << ir) : 0);
      chk("w_tna", 64'(w_tna), d[60] ? 0 : 64'(8'd1 << ir));
      chk("w_valid_drop", 64'(w_valid), 0);
      tick();
      chk("w_pulse_fall", 64'({w_ta, w_tna}), 0);
      repeat (3) tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
